// File: rtl/video_pattern_source.sv
// Video timing generator with selectable test patterns.
// One pixel per clock; pattern changes are applied on frame boundaries.
module video_pattern_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CHK_LOG2 = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [1:0]  i_pattern_sel,
  input  logic [23:0] i_solid_rgb,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_en,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // h also feeds the gray ramp (8 bits) and the checker bit,
  // so it is never narrower than either of those needs.
  localparam int HW0 = $clog2(H_TOTAL);
  localparam int HA  = (CHK_LOG2 + 1 > 8) ? CHK_LOG2 + 1 : 8;
  localparam int HW  = (HW0 > HA) ? HW0 : HA;
  localparam int VW0 = $clog2(V_TOTAL);
  localparam int VW  = (VW0 > CHK_LOG2 + 1) ? VW0 : CHK_LOG2 + 1;

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          last_h;
  logic          last_v;
  logic          frame_end;
  logic          load;

  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_pix;

  logic [1:0]    sel_q;
  logic [23:0]   solid_q;

  logic          act;
  logic          hs_on;
  logic          vs_on;
  logic [23:0]   pix;
  logic [23:0]   rgb;

  assign last_h    = (h == H_LAST);
  assign last_v    = (v == V_LAST);
  assign frame_end = (state != IDLE) && last_h && last_v;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; load marks the cycle whose edge puts counters at (0,0)
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_run) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (i_run) load      = 1'b1;
          else       state_nxt = IDLE;
        end else if (!i_run) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters; held at the origin while idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (state == IDLE) begin
      h <= '0;
      v <= '0;
    end else if (last_h) begin
      h <= '0;
      v <= last_v ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Bar index tracks h / BAR_W incrementally, saturating at the last bar
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (state == IDLE || last_h) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (bar_pix == B_LAST) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + 1'b1;
    end
  end

  // Pattern controls captured only at frame origin to avoid tearing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q   <= '0;
      solid_q <= '0;
    end else if (load) begin
      sel_q   <= i_pattern_sel;
      solid_q <= i_solid_rgb;
    end
  end

  // Timing windows from the current raster position
  always_comb begin
    act   = (h < H_ACT) && (v < V_ACT);
    hs_on = (h >= HS_BEG) && (h < HS_END);
    vs_on = (v >= VS_BEG) && (v < VS_END);
  end

  // Pixel colour for the current position
  always_comb begin
    pix = 24'h000000;
    unique case (sel_q)
      2'd0: begin
        unique case (bar_idx)
          3'd0: pix = 24'hFFFFFF;
          3'd1: pix = 24'hFFFF00;
          3'd2: pix = 24'h00FFFF;
          3'd3: pix = 24'h00FF00;
          3'd4: pix = 24'hFF00FF;
          3'd5: pix = 24'hFF0000;
          3'd6: pix = 24'h0000FF;
          3'd7: pix = 24'h000000;
          default: pix = 24'h000000;
        endcase
      end
      2'd1: pix = {3{h[7:0]}};
      2'd2: pix = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      2'd3: pix = solid_q;
      default: pix = 24'h000000;
    endcase
  end

  // Registered pin stage, one clock behind the counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_en          <= 1'b0;
      rgb           <= '0;
      o_frame_start <= 1'b0;
    end else if (state == IDLE) begin
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_en          <= 1'b0;
      rgb           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hs          <= hs_on ? HS_POL : ~HS_POL;
      o_vs          <= vs_on ? VS_POL : ~VS_POL;
      o_en          <= act;
      rgb           <= act ? pix : 24'h000000;
      o_frame_start <= (h == '0) && (v == '0);
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_frame_cnt <= '0;
    else if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
  end

  // Busy follows the state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_busy <= 1'b0;
    else          o_busy <= (state_nxt != IDLE);
  end

  assign o_r = rgb[23:16];
  assign o_g = rgb[15:8];
  assign o_b = rgb[7:0];

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source.
// Small raster: 24 clocks per line, 8 lines per frame.
module tb_video_pattern_source;

  localparam int HT = 24;
  localparam int FT = 192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [23:0] solid = 24'h0;
  logic        hs;
  logic        vs;
  logic        en;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        fs;
  logic [15:0] cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int pos = 0;

  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  video_pattern_source #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_run(run),
    .i_pattern_sel(sel),
    .i_solid_rgb(solid),
    .o_hs(hs),
    .o_vs(vs),
    .o_en(en),
    .o_r(r),
    .o_g(g),
    .o_b(b),
    .o_frame_start(fs),
    .o_frame_cnt(cnt),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic tick_to(input int t);
    while (pos < t) tick();
  endtask

  initial begin
    int bad;
    int en_n, hs_n, vs_n, hs_first;
    int bad_en, bad_hs, bad_vs, bad_fs, bad_rgb;
    int eh, ev;
    logic e_act, e_hs, e_vs;
    logic [23:0] e_rgb;

    // Reset state
    #12;
    chk("rst_hs", 32'(hs), 32'd0);
    chk("rst_vs", 32'(vs), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with run low
    bad = 0;
    repeat (1000) begin
      tick();
      if (en !== 1'b0 || hs !== 1'b0 || vs !== 1'b0 ||
          busy !== 1'b0 || cnt !== 16'd0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Start: busy next clock, first pixel the clock after
    run = 1'b1;
    sel = 2'd0;
    tick();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_en_early", 32'(en), 32'd0);
    tick();
    pos = 0;
    chk("first_en", 32'(en), 32'd1);
    chk("first_fs", 32'(fs), 32'd1);
    chk("first_rgb", 32'({r, g, b}), 32'hFFFFFF);

    // Whole first frame against the raster model
    en_n = 0; hs_n = 0; vs_n = 0; hs_first = -1;
    bad_en = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_rgb = 0;
    for (int i = 0; i < FT; i++) begin
      eh = i % HT;
      ev = i / HT;
      e_act = (eh < 16) && (ev < 4);
      e_hs = (eh >= 18) && (eh < 21);
      e_vs = (ev >= 5) && (ev < 7);
      e_rgb = e_act ? bars[eh / 2] : 24'h0;
      if (en !== e_act) bad_en++;
      if (hs !== e_hs) bad_hs++;
      if (vs !== e_vs) bad_vs++;
      if (fs !== (i == 0)) bad_fs++;
      if ({r, g, b} !== e_rgb) bad_rgb++;
      if (ev == 0 && eh < 16)
        chk($sformatf("bar_px%0d", eh), 32'({r, g, b}), 32'(e_rgb));
      if (en === 1'b1) en_n++;
      if (hs === 1'b1) hs_n++;
      if (vs === 1'b1) vs_n++;
      if (hs === 1'b1 && hs_first < 0) hs_first = i;
      tick();
    end
    chk("f0_en_count", 32'(en_n), 32'd64);
    chk("f0_hs_count", 32'(hs_n), 32'd24);
    chk("f0_vs_count", 32'(vs_n), 32'd48);
    chk("f0_hs_offset", 32'(hs_first), 32'd18);
    chk("f0_en_shape", 32'(bad_en), 32'd0);
    chk("f0_hs_shape", 32'(bad_hs), 32'd0);
    chk("f0_vs_shape", 32'(bad_vs), 32'd0);
    chk("f0_fs_shape", 32'(bad_fs), 32'd0);
    chk("f0_rgb_shape", 32'(bad_rgb), 32'd0);
    chk("f1_fs", 32'(fs), 32'd1);
    chk("f1_cnt", 32'(cnt), 32'd1);

    // Mid-frame switch to solid: applied only next frame
    tick_to(FT + 2 * HT + 5);
    sel = 2'd3;
    solid = 24'h123456;
    tick_to(FT + 3 * HT);
    chk("keep_bar0", 32'({r, g, b}), 32'hFFFFFF);
    tick_to(FT + 3 * HT + 2);
    chk("keep_bar1", 32'({r, g, b}), 32'hFFFF00);
    tick_to(2 * FT);
    chk("solid_px0", 32'({r, g, b}), 32'h123456);
    chk("f2_fs", 32'(fs), 32'd1);
    chk("f2_cnt", 32'(cnt), 32'd2);
    tick_to(2 * FT + 15);
    chk("solid_px15", 32'({r, g, b}), 32'h123456);
    tick();
    chk("blank_en", 32'(en), 32'd0);
    chk("blank_rgb", 32'({r, g, b}), 32'd0);

    // Checkerboard next frame
    tick_to(500);
    sel = 2'd2;
    tick_to(3 * FT + 7);
    chk("chk_px7", 32'({r, g, b}), 32'h000000);
    chk("chk_en7", 32'(en), 32'd1);
    tick_to(3 * FT + 8);
    chk("chk_px8", 32'({r, g, b}), 32'hFFFFFF);

    // Gray ramp next frame
    tick_to(700);
    sel = 2'd1;
    tick_to(4 * FT + 5);
    chk("gray_px5", 32'({r, g, b}), 32'h050505);
    tick_to(4 * FT + 15);
    chk("gray_px15", 32'({r, g, b}), 32'h0F0F0F);

    // Drop run during line 1: frame drains to completion
    tick_to(5 * FT + 30);
    run = 1'b0;
    tick_to(5 * FT + 3 * HT);
    chk("drain_en", 32'(en), 32'd1);
    chk("drain_busy", 32'(busy), 32'd1);
    tick_to(6 * FT - 2);
    chk("drain_busy_end", 32'(busy), 32'd1);
    chk("drain_cnt_pre", 32'(cnt), 32'd5);
    tick();
    chk("drain_busy_fall", 32'(busy), 32'd0);
    chk("drain_cnt_post", 32'(cnt), 32'd6);
    tick();
    chk("stop_en", 32'(en), 32'd0);
    chk("stop_fs", 32'(fs), 32'd0);

    // Restart: frame start two clocks after run rises
    tick_to(6 * FT + 8);
    run = 1'b1;
    tick();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_fs_early", 32'(fs), 32'd0);
    tick();
    chk("restart_fs", 32'(fs), 32'd1);
    chk("restart_en", 32'(en), 32'd1);
    tick();
    tick();
    tick();
    chk("restart_gray3", 32'({r, g, b}), 32'h030303);

    // Asynchronous reset mid-line
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_rgb", 32'({r, g, b}), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("arst_stay_idle", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
